// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: default widths,
// the reserved "no tag" value and the requester index map.
package cdb_arbiter_pkg;

  localparam int NREQ_DEF  = 3;
  localparam int TAG_W_DEF = 4;
  localparam int XLEN_DEF  = 32;
  localparam int RD_W      = 5;
  localparam int SRC_W     = 2;

  // Tag 0 means "no producer"; a result carrying it is never broadcast.
  localparam logic [TAG_W_DEF-1:0] TAG_NONE = '0;

  localparam logic [SRC_W-1:0] REQ_ALU = 2'd0;
  localparam logic [SRC_W-1:0] REQ_LSB = 2'd1;
  localparam logic [SRC_W-1:0] REQ_BR  = 2'd2;

  // Round-robin successor of a requester index, wrapping at nreq.
  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx,
                                                input int nreq);
    return ((int'(idx) + 1) >= nreq) ? '0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_slot.sv
// One holding register for a single producer's result. A load with the
// reserved tag is swallowed: the slot stays empty.
module cdb_slot
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [XLEN-1:0]  val_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [RD_W-1:0]  rd_i,
  output logic             full_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [XLEN-1:0]  val_o,
  output logic [XLEN-1:0]  addr_o,
  output logic [RD_W-1:0]  rd_o
);

  logic             full_q, full_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  val_q, val_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [RD_W-1:0]  rd_q, rd_d;

  // Next slot contents: flush beats load, a load replaces a granted entry.
  always_comb begin
    full_d = full_q;
    tag_d  = tag_q;
    val_d  = val_q;
    addr_d = addr_q;
    rd_d   = rd_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = (tag_i != '0);
      tag_d  = tag_i;
      val_d  = val_i;
      addr_d = addr_i;
      rd_d   = rd_i;
    end else if (clear_i) begin
      full_d = 1'b0;
    end
  end

  // Slot register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      tag_q  <= '0;
      val_q  <= '0;
      addr_q <= '0;
      rd_q   <= '0;
    end else begin
      full_q <= full_d;
      tag_q  <= tag_d;
      val_q  <= val_d;
      addr_q <= addr_d;
      rd_q   <= rd_d;
    end
  end

  assign full_o = full_q;
  assign tag_o  = tag_q;
  assign val_o  = val_q;
  assign addr_o = addr_q;
  assign rd_o   = rd_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between the ALU, the
// load/store buffer and the branch unit. One result is buffered per
// producer and one buffered result is broadcast per cycle, registered.
//
// Handshake: a producer result transfers on a rising edge where
// req_valid[i] && req_ready[i]. req_ready[i] does not depend on
// req_valid[i]; a producer holds its valid result until that transfer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  predict_fail,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic [NREQ*XLEN-1:0]  req_val,
  input  logic [NREQ*XLEN-1:0]  req_addr,
  input  logic [NREQ*RD_W-1:0]  req_rd,
  output logic                  cdb_active,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [XLEN-1:0]       cdb_val,
  output logic [XLEN-1:0]       cdb_addr,
  output logic [RD_W-1:0]       cdb_rd_idx,
  output logic [SRC_W-1:0]      cdb_src
);

  logic [NREQ-1:0]  slot_full;
  logic [TAG_W-1:0] slot_tag  [NREQ];
  logic [XLEN-1:0]  slot_val  [NREQ];
  logic [XLEN-1:0]  slot_addr [NREQ];
  logic [RD_W-1:0]  slot_rd   [NREQ];

  logic [NREQ-1:0]  grant;
  logic             win_found;
  logic [SRC_W-1:0] win_idx;
  logic [SRC_W-1:0] pos;
  logic [TAG_W-1:0] win_tag;
  logic [XLEN-1:0]  win_val;
  logic [XLEN-1:0]  win_addr;
  logic [RD_W-1:0]  win_rd;

  logic             flush;
  logic             accept_ok;

  logic             cdb_active_q, cdb_active_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]  cdb_val_q, cdb_val_d;
  logic [XLEN-1:0]  cdb_addr_q, cdb_addr_d;
  logic [RD_W-1:0]  cdb_rd_q, cdb_rd_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  assign flush     = rdy_in && predict_fail;
  assign accept_ok = rdy_in && !rst_in && !predict_fail;
  assign req_ready = accept_ok ? (~slot_full | grant) : '0;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    cdb_slot #(.TAG_W(TAG_W), .XLEN(XLEN)) u_slot (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .flush_i (flush),
      .load_i  (req_valid[g] && req_ready[g]),
      .clear_i (rdy_in && !predict_fail && grant[g]),
      .tag_i   (req_tag[g*TAG_W +: TAG_W]),
      .val_i   (req_val[g*XLEN +: XLEN]),
      .addr_i  (req_addr[g*XLEN +: XLEN]),
      .rd_i    (req_rd[g*RD_W +: RD_W]),
      .full_o  (slot_full[g]),
      .tag_o   (slot_tag[g]),
      .val_o   (slot_val[g]),
      .addr_o  (slot_addr[g]),
      .rd_o    (slot_rd[g])
    );
  end

  // Rotating-priority pick: first full slot at rr_ptr, rr_ptr+1, ...
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    win_tag   = '0;
    win_val   = '0;
    win_addr  = '0;
    win_rd    = '0;
    grant     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = SRC_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_found && slot_full[pos]) begin
        win_found  = 1'b1;
        win_idx    = pos;
        win_tag    = slot_tag[pos];
        win_val    = slot_val[pos];
        win_addr   = slot_addr[pos];
        win_rd     = slot_rd[pos];
        grant[pos] = 1'b1;
      end
    end
  end

  // Next broadcast and pointer; everything holds while rdy_in is low.
  always_comb begin
    cdb_active_d = cdb_active_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_val_d    = cdb_val_q;
    cdb_addr_d   = cdb_addr_q;
    cdb_rd_d     = cdb_rd_q;
    cdb_src_d    = cdb_src_q;
    rr_ptr_d     = rr_ptr_q;
    if (rdy_in) begin
      if (predict_fail) begin
        cdb_active_d = 1'b0;
        rr_ptr_d     = '0;
      end else if (win_found) begin
        cdb_active_d = 1'b1;
        cdb_tag_d    = win_tag;
        cdb_val_d    = win_val;
        cdb_addr_d   = win_addr;
        cdb_rd_d     = win_rd;
        cdb_src_d    = win_idx;
        rr_ptr_d     = rr_next(win_idx, NREQ);
      end else begin
        cdb_active_d = 1'b0;
      end
    end
  end

  // Registered CDB outputs and round-robin pointer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_active_q <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_val_q    <= '0;
      cdb_addr_q   <= '0;
      cdb_rd_q     <= '0;
      cdb_src_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      cdb_active_q <= cdb_active_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_val_q    <= cdb_val_d;
      cdb_addr_q   <= cdb_addr_d;
      cdb_rd_q     <= cdb_rd_d;
      cdb_src_q    <= cdb_src_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign cdb_active = cdb_active_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_val    = cdb_val_q;
  assign cdb_addr   = cdb_addr_q;
  assign cdb_rd_idx = cdb_rd_q;
  assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single result, backpressure, contention,
// throughput, flush, pause and reset mid-burst.
module tb_cdb_arbiter;

  localparam int NREQ  = 3;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_in;
  logic                  rdy_in;
  logic                  predict_fail;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [NREQ*XLEN-1:0]  req_val;
  logic [NREQ*XLEN-1:0]  req_addr;
  logic [NREQ*5-1:0]     req_rd;
  logic                  cdb_active;
  logic [TAG_W-1:0]      cdb_tag;
  logic [XLEN-1:0]       cdb_val;
  logic [XLEN-1:0]       cdb_addr;
  logic [4:0]            cdb_rd_idx;
  logic [1:0]            cdb_src;

  cdb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .predict_fail (predict_fail),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tag      (req_tag),
    .req_val      (req_val),
    .req_addr     (req_addr),
    .req_rd       (req_rd),
    .cdb_active   (cdb_active),
    .cdb_tag      (cdb_tag),
    .cdb_val      (cdb_val),
    .cdb_addr     (cdb_addr),
    .cdb_rd_idx   (cdb_rd_idx),
    .cdb_src      (cdb_src)
  );

  // A transfer with the reserved tag is a producer bug.
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_in && req_valid[i] && req_ready[i] && req_tag[i*TAG_W +: TAG_W] == '0)
        $error("tag-0 request accepted from requester %0d", i);
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [TAG_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] val_of(input logic [TAG_W-1:0] t);
    return 32'hA5A5_0000 | {28'h0, t};
  endfunction

  function automatic logic [XLEN-1:0] addr_of(input logic [TAG_W-1:0] t);
    return 32'h0000_8000 | {24'h0, t, 4'h0};
  endfunction

  function automatic logic [4:0] rd_of(input logic [TAG_W-1:0] t);
    return {1'b0, t};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val,
                         input logic [XLEN-1:0] addr, input logic [4:0] rd);
    req_valid[i]               = 1'b1;
    req_tag[i*TAG_W +: TAG_W]  = tag;
    req_val[i*XLEN +: XLEN]    = val;
    req_addr[i*XLEN +: XLEN]   = addr;
    req_rd[i*5 +: 5]           = rd;
  endtask

  task automatic set_std(input int i, input logic [TAG_W-1:0] tag);
    set_req(i, tag, val_of(tag), addr_of(tag), rd_of(tag));
  endtask

  task automatic clr_all();
    req_valid = '0;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_active"}, cdb_active, 0);
    check({name, "_tag"},    cdb_tag,    0);
    check({name, "_val"},    cdb_val,    0);
    check({name, "_addr"},   cdb_addr,   0);
    check({name, "_rd"},     cdb_rd_idx, 0);
    check({name, "_src"},    cdb_src,    0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    predict_fail = 1'b0;
    req_valid    = '0;
    req_tag      = '0;
    req_val      = '0;
    req_addr     = '0;
    req_rd       = '0;
    tick();
    tick();
    rst_in = 1'b0;
    check_zero_outputs("reset");
    #1;
    check("reset_ready", req_ready, 3'b111);

    // Single ALU result: broadcast two edges after the request.
    set_req(0, 4'd3, 32'h55, 32'h100, 5'd5);
    #1;
    check("single_ready", req_ready[0], 1);
    tick();
    clr_all();
    check("single_no_bypass", cdb_active, 0);
    tick();
    check("single_active", cdb_active, 1);
    check("single_tag",    cdb_tag,    3);
    check("single_val",    cdb_val,    32'h55);
    check("single_addr",   cdb_addr,   32'h100);
    check("single_rd",     cdb_rd_idx, 5);
    check("single_src",    cdb_src,    0);
    tick();
    check("single_idle",     cdb_active, 0);
    check("single_hold_tag", cdb_tag,    3);

    // Backpressure, rr_ptr=1: LSB then branch win while ALU waits.
    set_std(0, 4'd13);
    set_std(1, 4'd14);
    set_std(2, 4'd15);
    tick();
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b0;
    set_std(0, 4'd12);
    #1;
    check("bp_alu_ready_c1", req_ready[0], 0);
    tick();
    check("bp_tag_lsb", cdb_tag, 14);
    check("bp_src_lsb", cdb_src, 1);
    check("bp_alu_ready_c2", req_ready[0], 0);
    tick();
    check("bp_tag_br", cdb_tag, 15);
    check("bp_src_br", cdb_src, 2);
    check("bp_alu_ready_c3", req_ready[0], 1);
    tick();
    clr_all();
    check("bp_tag_alu", cdb_tag, 13);
    check("bp_src_alu", cdb_src, 0);
    #1;
    check("bp_alu_ready_reload", req_ready[0], 1);
    tick();
    check("bp_active_alu2", cdb_active, 1);
    check("bp_tag_alu2",    cdb_tag,    12);
    check("bp_val_alu2",    cdb_val,    val_of(4'd12));
    tick();
    check("bp_idle", cdb_active, 0);

    // Contention from rr_ptr=0 after a reset pulse.
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    set_std(0, 4'd1);
    set_std(1, 4'd2);
    set_std(2, 4'd3);
    tick();
    clr_all();
    check("cont_latency", cdb_active, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("cont_active", cdb_active, 1);
      check("cont_tag",    cdb_tag,    k + 1);
      check("cont_src",    cdb_src,    k);
      check("cont_addr",   cdb_addr,   addr_of(TAG_W'(k + 1)));
    end

    // Second burst must start again from the ALU.
    set_std(0, 4'd10);
    set_std(1, 4'd11);
    set_std(2, 4'd12);
    exp_q.push_back(4'd10);
    exp_q.push_back(4'd11);
    exp_q.push_back(4'd12);
    tick();
    clr_all();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (cdb_active) begin
        if (exp_q.size() == 0) begin
          check("sb_extra", cdb_active, 0);
        end else begin
          check("sb_tag", cdb_tag, exp_q.pop_front());
        end
      end
    end
    check("sb_drain", exp_q.size(), 0);

    // Throughput: LSB streams one result per cycle.
    for (int k = 0; k < 4; k++) begin
      set_std(1, TAG_W'(4 + k));
      #1;
      check("tp_ready", req_ready[1], 1);
      tick();
      if (k > 0) begin
        check("tp_active", cdb_active, 1);
        check("tp_tag",    cdb_tag,    3 + k);
      end
    end
    clr_all();
    tick();
    check("tp_last_active", cdb_active, 1);
    check("tp_last_tag",    cdb_tag,    7);
    check("tp_last_rd",     cdb_rd_idx, rd_of(4'd7));
    tick();
    check("tp_idle", cdb_active, 0);

    // Flush discards the pending broadcast and both buffered results.
    set_std(0, 4'd8);
    set_std(1, 4'd9);
    tick();
    clr_all();
    predict_fail = 1'b1;
    #1;
    check("flush_ready_low", req_ready, 3'b000);
    tick();
    predict_fail = 1'b0;
    check("flush_active", cdb_active, 0);
    #1;
    check("flush_ready_after", req_ready, 3'b111);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("flush_no_bcast", cdb_active, 0);
    end

    // Pause mid-burst: outputs frozen, then resume in order.
    set_std(0, 4'd5);
    set_std(1, 4'd6);
    set_std(2, 4'd7);
    tick();
    clr_all();
    tick();
    check("pause_first_tag", cdb_tag, 5);
    rdy_in = 1'b0;
    #1;
    check("pause_ready", req_ready, 3'b000);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("pause_active", cdb_active, 1);
      check("pause_tag",    cdb_tag,    5);
      check("pause_src",    cdb_src,    0);
    end
    rdy_in = 1'b1;
    tick();
    check("resume_tag1", cdb_tag, 6);
    check("resume_src1", cdb_src, 1);
    tick();
    check("resume_tag2", cdb_tag, 7);
    check("resume_src2", cdb_src, 2);
    tick();
    check("resume_idle", cdb_active, 0);

    // Reset mid-burst clears outputs and buffered results.
    set_std(0, 4'd1);
    set_std(1, 4'd2);
    set_std(2, 4'd3);
    tick();
    clr_all();
    tick();
    check("rst_mid_first_tag", cdb_tag, 1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_zero_outputs("rst_mid");
    #1;
    check("rst_mid_ready", req_ready, 3'b111);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_mid_no_bcast", cdb_active, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
